// File: rtl/tqv_counter_pkg.sv
// Shared constants and sizing helpers for the nibble-serial counter.
package tqv_counter_pkg;

    localparam int NIBBLE_W = 4;

    function automatic int calc_nibbles(input int width);
        return width / NIBBLE_W;
    endfunction

    function automatic int calc_idx_w(input int width);
        return $clog2(width / NIBBLE_W);
    endfunction

endpackage

// File: rtl/tqv_nibble_add.sv
// 4-bit adder with carry-in and carry-out, one nibble of the serial datapath.
module tqv_nibble_add
    import tqv_counter_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/tqv_serial_counter.sv
// Nibble-serial WIDTH-bit counter driven by an external nibble sequencer.
// Define TQV_COUNTER_CMP_EN to build in the per-pass compare/match logic.
module tqv_serial_counter
    import tqv_counter_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int NIBBLES = calc_nibbles(WIDTH),
    localparam int IDX_W   = calc_idx_w(WIDTH)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [IDX_W-1:0]    nibble_idx,
    input  logic                add,
    input  logic [NIBBLE_W-1:0] step,
    input  logic                load,
    input  logic [NIBBLE_W-1:0] load_data,
    input  logic [NIBBLE_W-1:0] cmp_data,
    output logic [NIBBLE_W-1:0] data,
    output logic                wrap,
    output logic                match
);

    logic [WIDTH-1:0]    value;
    logic                carry;
    logic [NIBBLE_W-1:0] cur;
    logic [NIBBLE_W-1:0] addend;
    logic [NIBBLE_W-1:0] sum;
    logic [NIBBLE_W-1:0] new_nib;
    logic                cin;
    logic                cout;
    logic                first;
    logic                last;

    assign first = (nibble_idx == '0);
    assign last  = (nibble_idx == IDX_W'(NIBBLES - 1));

    always_comb begin
        cur = '0;
        for (int i = 0; i < NIBBLES; i++)
            if (nibble_idx == IDX_W'(i)) cur = value[i*NIBBLE_W +: NIBBLE_W];
    end

    // Nibble 0 takes the step as its addend; later nibbles ripple the stored carry.
    assign addend = (first && add) ? step : '0;
    assign cin    = !first && carry;

    tqv_nibble_add u_add (
        .a    (cur),
        .b    (addend),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    assign new_nib = load ? load_data : sum;
    assign data    = rstn ? new_nib : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            value <= '0;
            carry <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            for (int i = 0; i < NIBBLES; i++)
                if (nibble_idx == IDX_W'(i)) value[i*NIBBLE_W +: NIBBLE_W] <= new_nib;
            // A loaded nibble breaks the carry chain, which also suppresses wrap.
            carry <= !load && cout;
            wrap  <= last && !load && cout;
        end
    end

`ifdef TQV_COUNTER_CMP_EN
    logic acc;
    logic acc_next;

    assign acc_next = (first || acc) && (new_nib == cmp_data);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc   <= 1'b0;
            match <= 1'b0;
        end else begin
            acc   <= acc_next;
            match <= last && acc_next;
        end
    end
`else
    logic unused_cmp;
    assign unused_cmp = ^cmp_data;
    assign match      = 1'b0;
`endif

endmodule
